// File: rtl/seg7_serial_capture.sv
// seg7_serial_capture: oversampling receiver for the serial 7-segment link.
// Deserialises 64-bit frames, checks their length and decodes each segment byte to a hex digit.
module seg7_serial_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg_clk,
    input  logic        seg_sout,
    input  logic        SEG_PEN,
    input  logic        seg_clrn,
    output logic [31:0] hexs,
    output logic [7:0]  points,
    output logic [7:0]  digit_bad,
    output logic [63:0] raw,
    output logic        frame_valid,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVF} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, sout_sync, pen_sync, clrn_sync;
    logic                   clk_prev, pen_prev;
    logic                   clk_rise, pen_rise, sout_s, clrn_s;

    state_t      state;
    logic [6:0]  bitcnt;
    logic [63:0] shreg, frame_q;
    logic        commit_q, err_q;

    logic [31:0] dec_hexs;
    logic [7:0]  dec_points, dec_bad;
    logic [4:0]  dec_digit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= '0;
            sout_sync <= '0;
            pen_sync  <= '0;
            clrn_sync <= '0;
            clk_prev  <= 1'b0;
            pen_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], seg_clk};
            sout_sync <= {sout_sync[SYNC_STAGES-2:0], seg_sout};
            pen_sync  <= {pen_sync[SYNC_STAGES-2:0], SEG_PEN};
            clrn_sync <= {clrn_sync[SYNC_STAGES-2:0], seg_clrn};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            pen_prev  <= pen_sync[SYNC_STAGES-1];
        end
    end

    assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign pen_rise = pen_sync[SYNC_STAGES-1] & ~pen_prev;
    assign sout_s   = sout_sync[SYNC_STAGES-1];
    assign clrn_s   = clrn_sync[SYNC_STAGES-1];

    // Priority: link clear, then PEN, then a shift edge (a coincident edge is dropped).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            frame_q  <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            if (!clrn_s) begin
                state  <= IDLE;
                bitcnt <= '0;
                shreg  <= '0;
            end else if (pen_rise) begin
                if (state == FULL) begin
                    commit_q <= 1'b1;
                    frame_q  <= shreg;
                end else begin
                    err_q <= 1'b1;
                end
                state  <= IDLE;
                bitcnt <= '0;
                shreg  <= '0;
            end else if (clk_rise) begin
                shreg <= {shreg[62:0], sout_s};
                case (state)
                    IDLE: begin
                        bitcnt <= 7'd1;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        bitcnt <= bitcnt + 7'd1;
                        if (bitcnt == 7'd63) state <= FULL;
                    end
                    FULL: begin
                        bitcnt <= 7'd65;
                        state  <= OVF;
                    end
                    default: begin
                        bitcnt <= 7'd65;
                        state  <= OVF;
                    end
                endcase
            end
        end
    end

    function automatic logic [4:0] seg_decode(input logic [7:0] seg_byte);
        logic [6:0] lit;
        logic [4:0] res;
        lit = ~seg_byte[6:0];
        case (lit)
            7'h3F: res = 5'h00;
            7'h06: res = 5'h01;
            7'h5B: res = 5'h02;
            7'h4F: res = 5'h03;
            7'h66: res = 5'h04;
            7'h6D: res = 5'h05;
            7'h7D: res = 5'h06;
            7'h07: res = 5'h07;
            7'h7F: res = 5'h08;
            7'h6F: res = 5'h09;
            7'h77: res = 5'h0A;
            7'h7C: res = 5'h0B;
            7'h39: res = 5'h0C;
            7'h5E: res = 5'h0D;
            7'h79: res = 5'h0E;
            7'h71: res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    always_comb begin
        dec_hexs   = '0;
        dec_points = '0;
        dec_bad    = '0;
        dec_digit  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            dec_digit         = seg_decode(frame_q[8*i +: 8]);
            dec_hexs[4*i +: 4] = dec_digit[3:0];
            dec_bad[i]        = dec_digit[4];
            dec_points[i]     = ~frame_q[8*i+7];
        end
    end

    // Outputs trail the FSM decision by one cycle so decode works from a registered frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hexs        <= '0;
            points      <= '0;
            digit_bad   <= '0;
            raw         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit_q;
            frame_err   <= err_q;
            if (commit_q) begin
                raw       <= frame_q;
                hexs      <= dec_hexs;
                points    <= dec_points;
                digit_bad <= dec_bad;
            end
        end
    end
endmodule

// File: tb/tb_seg7_serial_capture.sv
// Self-checking bench for seg7_serial_capture: table vectors, corner sequences and
// random frames checked against a bit-queue reference model.
module tb_seg7_serial_capture;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst, seg_clk, seg_sout, SEG_PEN, seg_clrn;
    logic [31:0] hexs;
    logic [7:0]  points, digit_bad;
    logic [63:0] raw;
    logic        frame_valid, frame_err;

    int total = 0;
    int bad   = 0;

    seg7_serial_capture #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .seg_clk(seg_clk), .seg_sout(seg_sout),
        .SEG_PEN(SEG_PEN), .seg_clrn(seg_clrn), .hexs(hexs), .points(points),
        .digit_bad(digit_bad), .raw(raw), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Raw byte for each hex digit with the decimal point dark.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    bit          model_q[$];
    logic [31:0] m_hexs = '0;
    logic [7:0]  m_points = '0, m_bad = '0;
    logic [63:0] m_raw = '0;
    int          m_valid = 0, m_err = 0;

    int   cyc = 0, n_valid = 0, n_err = 0, last_pulse = 0;
    bit   overlap = 0, repeat_seen = 0;
    logic prev_v = 1'b0, prev_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin n_valid++; last_pulse = cyc; end
        if (frame_err) begin n_err++; last_pulse = cyc; end
        if (frame_valid && frame_err) overlap = 1;
        if ((frame_valid && prev_v) || (frame_err && prev_e)) repeat_seen = 1;
        prev_v = frame_valid;
        prev_e = frame_err;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic send_bit(input bit b);
        seg_sout = b;
        model_q.push_back(b);
        repeat (4) @(negedge clk);
        seg_clk = 1'b1;
        repeat (4) @(negedge clk);
        seg_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(i < 64 ? w[63-i] : 1'b0);
    endtask

    task automatic model_pen();
        logic [63:0] w;
        logic [7:0]  by;
        bit          found;
        if (model_q.size() == 64) begin
            for (int i = 0; i < 64; i++) w[63-i] = model_q[i];
            m_raw = w; m_hexs = '0; m_points = '0; m_bad = '0;
            for (int d = 0; d < 8; d++) begin
                by = w[8*d +: 8];
                found = 0;
                m_points[d] = ~by[7];
                for (int n = 0; n < 16; n++)
                    if ((by | 8'h80) == seg_tab[n]) begin
                        m_hexs[4*d +: 4] = n[3:0];
                        found = 1;
                    end
                m_bad[d] = !found;
            end
            m_valid++;
        end else begin
            m_err++;
        end
        model_q.delete();
    endtask

    task automatic check_outputs(input string name);
        check({name, ".hexs"}, hexs, m_hexs);
        check({name, ".points"}, points, m_points);
        check({name, ".bad"}, digit_bad, m_bad);
        check({name, ".raw"}, raw, m_raw);
    endtask

    task automatic do_pen(input string name, input bit with_edge, output int lat);
        int v0, e0, mv0, me0, t0;
        v0 = n_valid; e0 = n_err; mv0 = m_valid; me0 = m_err;
        @(negedge clk);
        SEG_PEN = 1'b1;
        if (with_edge) seg_clk = 1'b1;
        t0 = cyc;
        model_pen();
        repeat (4) @(negedge clk);
        SEG_PEN = 1'b0;
        seg_clk = 1'b0;
        repeat (6) @(negedge clk);
        check({name, ".valid"}, n_valid - v0, m_valid - mv0);
        check({name, ".err"}, n_err - e0, m_err - me0);
        check_outputs(name);
        lat = last_pulse - t0;
    endtask

    typedef struct {
        logic [63:0] frame;
        int          nbits;
        logic [31:0] hexs;
        logic [7:0]  points;
        logic [7:0]  bad;
        int          valid;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, v0;
        logic [63:0] w;
        logic [7:0]  b;
        int          nb;

        vecs[0] = '{64'hC0F9A4B0999282F8, 64, 32'h01234567, 8'h00, 8'h00, 1};
        vecs[1] = '{64'h808080808080800E, 64, 32'h8888888F, 8'h01, 8'h00, 1};
        vecs[2] = '{64'hC0C0C0C0C0C0C0C0, 63, 32'h8888888F, 8'h01, 8'h00, 0};
        vecs[3] = '{64'hC0C0C0C0C0C0C0C0, 65, 32'h8888888F, 8'h01, 8'h00, 0};
        vecs[4] = '{64'h8883C6A1868E9080, 64, 32'hABCDEF98, 8'h00, 8'h00, 1};
        vecs[5] = '{64'hC0F9A4B0FF9282F8, 64, 32'h01230567, 8'h00, 8'h08, 1};
        vecs[6] = '{64'h4079243019120278, 64, 32'h01234567, 8'hFF, 8'h00, 1};

        rst = 1'b0; seg_clk = 1'b0; seg_sout = 1'b0; SEG_PEN = 1'b0; seg_clrn = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs("reset");
        check("reset.fv", {frame_valid, frame_err}, 2'b00);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            send_bits(vecs[k].frame, vecs[k].nbits);
            v0 = n_valid;
            do_pen($sformatf("vec%0d", k), 1'b0, lat);
            check($sformatf("vec%0d.tab_valid", k), n_valid - v0, vecs[k].valid);
            check($sformatf("vec%0d.tab_hexs", k), hexs, vecs[k].hexs);
            check($sformatf("vec%0d.tab_points", k), points, vecs[k].points);
            check($sformatf("vec%0d.tab_bad", k), digit_bad, vecs[k].bad);
            if (k == 0) check("latency", lat, SYNC_STAGES + 2);
        end

        // Clear after 30 bits: partial frame vanishes, no error pulse.
        send_bits(64'hFFFFFFFFFFFFFFFF, 30);
        v0 = n_err;
        @(negedge clk); seg_clrn = 1'b0;
        repeat (4) @(negedge clk); seg_clrn = 1'b1;
        repeat (4) @(negedge clk);
        model_q.delete();
        check("clear.no_err", n_err - v0, 0);
        check("clear.outputs_held", hexs, 32'h01234567);
        send_bits(vecs[4].frame, 64);
        do_pen("after_clear", 1'b0, lat);

        // Edge coincident with PEN is dropped: 64 bits still commits, 63 still errors.
        send_bits(vecs[0].frame, 64);
        do_pen("coincide64", 1'b1, lat);
        send_bits(vecs[1].frame, 63);
        do_pen("coincide63", 1'b1, lat);

        for (int r = 0; r < 16; r++) begin
            for (int d = 0; d < 8; d++) begin
                if ($urandom_range(0, 9) == 0) b = 8'($urandom);
                else begin
                    b = seg_tab[$urandom_range(0, 15)];
                    if ($urandom_range(0, 1) == 1) b[7] = 1'b0;
                end
                w[8*d +: 8] = b;
            end
            nb = ($urandom_range(0, 4) == 0) ? 62 + 2 * $urandom_range(0, 2) - $urandom_range(0, 1) : 64;
            send_bits(w, nb);
            do_pen($sformatf("rand%0d", r), 1'b0, lat);
        end

        // Reset mid-frame clears outputs; next frame starts from bit 0.
        send_bits(vecs[5].frame, 20);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        model_q.delete();
        m_hexs = '0; m_points = '0; m_bad = '0; m_raw = '0;
        check_outputs("midreset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_bits(vecs[6].frame, 64);
        do_pen("post_reset", 1'b0, lat);
        check("post_reset.hexs_tab", hexs, 32'h01234567);

        check("overlap", overlap, 0);
        check("repeat_pulse", repeat_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
